tdm_demux: RTL and testbench
============================

# tdm_demux

Sequential 1:N time-division demultiplexer and deserializer. It is the receive end of the select-counter-driven N:1 multiplexer path.
- A serial stream arrives one bit per valid cycle; slot k of a frame carries input I[k] of the far-end mux.
- The block rebuilds the N-bit word, presents it on a registered parallel output, and flags framing errors.
- It sits between the serial link and the parallel consumer logic.

## Interface
Parameters:
- N, default 4: slots per frame and width of the parallel output. Legal values are N >= 2; N need not be a power of two.
- P, default $clog2(N): slot counter / select width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- din  input  1  serial data bit.
- din_valid  input  1  din carries a slot bit this cycle.
- frame_start  input  1  marks the current valid bit as slot 0. Only meaningful while din_valid=1.
- Y  output  N  last completed word. Bit k holds the slot-k bit.
- y_valid  output  1  one-cycle pulse: Y has just been updated.
- slot  output  P  index of the next expected slot (demux select, for monitoring).
- busy  output  1  a frame is in progress (state RECV).
- frame_err  output  1  one-cycle pulse: the current frame was aborted.

## Operation
States:
- IDLE: waiting for a frame.
- RECV: collecting slots 1..N-1.

IDLE:
- din_valid=1 with frame_start=1: shift_reg[0]<=din, slot<=1, go to RECV.
- din_valid=1 without frame_start: the bit is discarded. No error, no state change.
- frame_start=1 with din_valid=0: ignored.

RECV:
- din_valid=0: hold everything. Gaps of any length are allowed.
- din_valid=1, frame_start=0, slot<N-1: shift_reg[slot]<=din, slot<=slot+1.
- din_valid=1, frame_start=0, slot==N-1:
  - Y <= {din, shift_reg[N-2:0]}.
  - y_valid pulses.
  - slot<=0, go to IDLE.
- din_valid=1, frame_start=1 (start arrives mid-frame):
  - frame_err pulses; the partial word is discarded and Y is unchanged.
  - The current bit is taken as the new slot 0: shift_reg[0]<=din, slot<=1, stay in RECV.

General rules:
- The slot counter never exceeds N-1 and wraps to 0 at the end of a frame, including when N is not a power of two.
- Y only changes on a completed frame. It holds its value otherwise, including across error frames.
- shift_reg bits beyond the current slot may be stale. They are never visible on Y because every completed frame overwrites all N bits.
- busy = (state == RECV).

## Timing
- All outputs are registered.
- Reset values while rst_n=0: Y=0, y_valid=0, frame_err=0, slot=0, busy=0, state IDLE, shift_reg=0.
- Assertion of rst_n is asynchronous and takes effect immediately, even mid-frame. The partial frame is lost.
- Release of rst_n is assumed synchronous to clk.
- Latency: Y and y_valid update on the same rising edge that samples the slot N-1 bit. They are visible in the following cycle.
- A frame takes a minimum of N valid cycles.
- Back-to-back frames with zero idle cycles are supported: frame_start may be asserted on the cycle immediately after the slot N-1 bit.
- The y_valid and frame_err pulses last exactly 1 cycle each and are never asserted together.

## Test plan
- Reset and basic frame (N=4):
  - Stimulus: assert rst_n=0 and check all outputs are 0. Release, then send slots 0..3 = 0,1,0,1 on consecutive cycles with frame_start on slot 0.
  - Required response: Y=4'b1010, y_valid high for exactly 1 cycle, slot sequence 1,2,3,0.
- Per-slot selection:
  - Stimulus: four frames, each with a single 1 in slot k (k = 0..3).
  - Required response: Y = 4'b0001, 4'b0010, 4'b0100, 4'b1000.
- Gaps and back-to-back:
  - Stimulus: frame 4'b1100 with din_valid=0 for 3 cycles between slots 1 and 2. Immediately follow it with frame 4'b0011 with no idle cycle.
  - Required response: two y_valid pulses; Y=4'b1100, then 4'b0011. slot holds its value during the gap.
- Framing error:
  - Stimulus: after slots 0,1 of a frame, assert frame_start again, then send 4 bits forming 4'b0110.
  - Required response: frame_err pulse at the restart, no y_valid for the aborted frame, Y stays at its previous value, then Y=4'b0110.
- Stray data and mid-frame reset:
  - Stimulus: valid bits in IDLE without frame_start. Then start a frame and assert rst_n=0 after slot 2.
  - Required response: stray bits are ignored (no pulses, slot=0). On reset, all outputs are 0 immediately and the next full frame decodes correctly.
- Non-power-of-two:
  - Stimulus: N=5, P=3; frame 5'b10110.
  - Required response: Y=5'b10110, slot wraps 4 -> 0 and never reaches 5.

Source files
------------

// File: rtl/tdm_demux.sv
// ---------------------------------------------------------------------------
// tdm_demux
//
// Receive end of a select-counter-driven N:1 time-division link. Serial bits
// arrive one per valid cycle. Slot k of a frame holds bit k of the far-end
// word. The block rebuilds the word, presents it on a registered parallel
// output, and flags frames that are aborted by an early frame_start.
//
// Parameters
//   N  slots per frame and width of Y (N >= 2, any value)
//   P  width of the slot counter / demux select
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   din          serial data bit
//   din_valid    din carries a slot bit this cycle
//   frame_start  current valid bit is slot 0 (ignored unless din_valid)
//   Y            last completed word, bit k = slot-k bit
//   y_valid      one-cycle pulse, Y has just been updated
//   slot         index of the next expected slot
//   busy         a frame is in progress
//   frame_err    one-cycle pulse, the frame in progress was aborted
// ---------------------------------------------------------------------------
module tdm_demux #(
    parameter int N = 4,
    parameter int P = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         din,
    input  logic         din_valid,
    input  logic         frame_start,
    output logic [N-1:0] Y,
    output logic         y_valid,
    output logic [P-1:0] slot,
    output logic         busy,
    output logic         frame_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    // The counter wraps at N-1 explicitly, so non-power-of-two N never
    // lets it reach N.
    localparam logic [P-1:0] LAST_SLOT = P'(N - 1);

    state_t         state_q, state_d;
    logic [P-1:0]   slot_q, slot_d;
    logic [N-1:0]   shift_q, shift_d;
    logic [N-1:0]   y_q, y_d;
    logic           y_valid_q, y_valid_d;
    logic           frame_err_q, frame_err_d;

    // Shift-register write port: one bit per valid cycle.
    logic           wr_en;
    logic [P-1:0]   wr_idx;

    // ---------------------------------------------------------------
    // State and datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            slot_q      <= '0;
            shift_q     <= '0;
            y_q         <= '0;
            y_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            shift_q     <= shift_d;
            y_q         <= y_d;
            y_valid_q   <= y_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (din_valid && frame_start) begin
                    state_d = RECV;
                end
            end
            RECV: begin
                // A mid-frame frame_start restarts the frame and stays in RECV.
                if (din_valid && !frame_start && (slot_q == LAST_SLOT)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Output / datapath next values
    // ---------------------------------------------------------------
    always_comb begin
        slot_d      = slot_q;
        y_d         = y_q;
        y_valid_d   = 1'b0;
        frame_err_d = 1'b0;
        wr_en       = 1'b0;
        wr_idx      = slot_q;

        if (din_valid) begin
            if (frame_start) begin
                // Start of a frame; in RECV this also aborts the partial word,
                // leaving Y untouched.
                frame_err_d = (state_q == RECV);
                wr_en       = 1'b1;
                wr_idx      = '0;
                slot_d      = P'(1);
            end else if (state_q == RECV) begin
                if (slot_q == LAST_SLOT) begin
                    // Last slot goes straight to Y; every bit of Y is rewritten,
                    // so stale shift_q bits from an aborted frame never leak out.
                    y_d       = {din, shift_q[N-2:0]};
                    y_valid_d = 1'b1;
                    slot_d    = '0;
                end else begin
                    wr_en  = 1'b1;
                    slot_d = slot_q + P'(1);
                end
            end
            // Valid bits in IDLE without frame_start are dropped silently.
        end
    end

    // Per-bit demux into the shift register.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_shift
            assign shift_d[gi] = (wr_en && (wr_idx == P'(gi))) ? din : shift_q[gi];
        end
    endgenerate

    assign Y         = y_q;
    assign y_valid   = y_valid_q;
    assign slot      = slot_q;
    assign busy      = (state_q == RECV);
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// ---------------------------------------------------------------------------
// tb_tdm_demux
//
// Two instances (N=4 and N=5) see the same serial stream. A reference model
// collects bits per frame and queues the expected pulses (completed words or
// aborts). A monitor on the falling edge pops the queue whenever a DUT
// pulses, and checks Y, slot and busy every cycle.
// ---------------------------------------------------------------------------
module tb_tdm_demux;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic din = 1'b0;
    logic din_valid = 1'b0;
    logic frame_start = 1'b0;
    logic done = 1'b0;

    logic [3:0] y4;
    logic       yv4, fe4, busy4;
    logic [1:0] slot4;
    logic [4:0] y5;
    logic       yv5, fe5, busy5;
    logic [2:0] slot5;

    tdm_demux #(.N(4), .P(2)) u_n4 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .frame_start(frame_start), .Y(y4), .y_valid(yv4), .slot(slot4),
        .busy(busy4), .frame_err(fe4)
    );

    tdm_demux #(.N(5), .P(3)) u_n5 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .frame_start(frame_start), .Y(y5), .y_valid(yv5), .slot(slot5),
        .busy(busy5), .frame_err(fe5)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: per instance, bits gathered so far in the current frame.
    bit         act  [2];
    int         cnt  [2];
    logic [7:0] acc  [2];
    logic [7:0] last [2];
    // Expected pulse entries: bit 8 = abort, bits 7:0 = word.
    logic [8:0] q0[$];
    logic [8:0] q1[$];

    function automatic int nof(input int i);
        return (i == 0) ? 4 : 5;
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s N=%0d got=%0h want=%0h t=%0t", name, nof(i), got, want, $time);
        end
    endtask

    task automatic push_exp(input int i, input logic [8:0] e);
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            act[i]  = 1'b0;
            cnt[i]  = 0;
            acc[i]  = '0;
            last[i] = '0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic model_step(input int i, input logic d, input logic v, input logic s);
        if (v) begin
            if (s) begin
                if (act[i]) push_exp(i, {1'b1, last[i]});
                act[i] = 1'b1;
                acc[i] = '0;
                acc[i][0] = d;
                cnt[i] = 1;
            end else if (act[i]) begin
                acc[i][cnt[i]] = d;
                cnt[i]++;
                if (cnt[i] == nof(i)) begin
                    last[i] = acc[i];
                    push_exp(i, {1'b0, acc[i]});
                    act[i] = 1'b0;
                    cnt[i] = 0;
                end
            end
        end
    endtask

    task automatic mon(input int i, input logic [7:0] y, input logic yv, input logic fe,
                       input logic [7:0] sl, input logic bz);
        logic [8:0] e;
        int         pend;
        chk("pulse_exclusive", i, {31'd0, yv & fe}, 32'd0);
        if (yv || fe) begin
            pend = (i == 0) ? q0.size() : q1.size();
            if (pend == 0) begin
                chk("unexpected_pulse", i, {30'd0, yv, fe}, 32'd0);
            end else begin
                if (i == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk("pulse_kind", i, {30'd0, yv, fe}, e[8] ? 32'd1 : 32'd2);
                if (yv) chk("word", i, {24'd0, y}, {24'd0, e[7:0]});
            end
        end
        chk("Y_hold", i, {24'd0, y}, {24'd0, last[i]});
        chk("slot", i, {24'd0, sl}, act[i] ? cnt[i] : 0);
        chk("busy", i, {31'd0, bz}, {31'd0, act[i]});
        chk("slot_range", i, {31'd0, (int'(sl) < nof(i))}, 32'd1);
        pend = (i == 0) ? q0.size() : q1.size();
        chk("missing_pulse", i, pend, 32'd0);
        if (i == 0) q0.delete();
        else        q1.delete();
    endtask

    // Model + monitor. At each falling edge the DUT state reflects the last
    // rising edge; the model is then advanced with the inputs that the next
    // rising edge will sample.
    initial model_reset();
    always @(negedge clk) begin
        if (!rst_n) model_reset();
        mon(0, {4'd0, y4}, yv4, fe4, {6'd0, slot4}, busy4);
        mon(1, {3'd0, y5}, yv5, fe5, {5'd0, slot5}, busy5);
        if (done) begin
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
        if (rst_n) begin
            model_step(0, din, din_valid, frame_start);
            model_step(1, din, din_valid, frame_start);
        end
    end

    // ---------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------
    task automatic send(input logic d, input logic v, input logic s);
        @(posedge clk);
        #1;
        din         = d;
        din_valid   = v;
        frame_start = s;
    endtask

    task automatic send_frame(input logic [7:0] w, input int n, input int gap_at, input int gaplen);
        for (int k = 0; k < n; k++) begin
            if (k == gap_at) repeat (gaplen) send(1'b0, 1'b0, 1'b0);
            send(w[k], 1'b1, (k == 0));
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic frame, slots 0..3 = 0,1,0,1
        send_frame(8'b1010, 4, -1, 0);
        send(1'b0, 1'b0, 1'b0);

        // One hot per slot
        for (int k = 0; k < 4; k++) send_frame(8'd1 << k, 4, -1, 0);
        send(1'b0, 1'b0, 1'b0);

        // Gap between slots 1 and 2, then back-to-back frame
        send_frame(8'b1100, 4, 2, 3);
        send_frame(8'b0011, 4, -1, 0);
        send(1'b0, 1'b0, 1'b0);

        // Framing error after two slots, then a good frame
        send(1'b1, 1'b1, 1'b1);
        send(1'b1, 1'b1, 1'b0);
        send_frame(8'b0110, 4, -1, 0);
        send(1'b0, 1'b0, 1'b0);

        // Stray data in IDLE and frame_start without din_valid
        send(1'b1, 1'b1, 1'b0);
        send(1'b0, 1'b1, 1'b0);
        send(1'b1, 1'b0, 1'b1);
        send(1'b1, 1'b1, 1'b0);

        // Mid-frame reset after slot 2
        send(1'b1, 1'b1, 1'b1);
        send(1'b1, 1'b1, 1'b0);
        send(1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        din_valid = 1'b0;
        send(1'b1, 1'b1, 1'b1);
        send(1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        din_valid = 1'b0;
        frame_start = 1'b0;
        send_frame(8'b1001, 4, -1, 0);
        send(1'b0, 1'b0, 1'b0);

        // Non-power-of-two frame for the N=5 instance
        send_frame(8'b10110, 5, -1, 0);
        send(1'b0, 1'b0, 1'b0);

        // Random whole frames with random gaps
        for (int r = 0; r < 40; r++) begin
            int n;
            n = ($urandom_range(0, 1) == 0) ? 4 : 5;
            send_frame(8'($urandom), n, $urandom_range(1, n - 1), $urandom_range(0, 2));
        end

        // Fully random serial traffic
        for (int r = 0; r < 600; r++) begin
            send(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0));
        end

        send(1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b0, 1'b0);
        done = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
